// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The FSM encoding, grant type and fetch byte-enable constant live here.
package mem_port_arbiter_pkg;

    localparam int         WORD_BITWIDTH_DEFAULT = 32;
    localparam logic [3:0] FETCH_BE              = 4'hF;
    localparam logic [3:0] RESET_BE              = 4'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } grant_e;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive data grants made while fetch is waiting; saturates at LIMIT.
// 'sat' tells the arbiter that fetch must win the next contested grant.
module starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int CNT_W = cnt_width(LIMIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic             sat,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(LIMIT);

    assign sat = (cnt == LIMIT_VAL);

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and the data (MEM) stage.
// Data has priority; a saturating starvation counter eventually forces a fetch grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_BITWIDTH = WORD_BITWIDTH_DEFAULT,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_req,
    input  logic [WORD_BITWIDTH-1:0] if_addr,
    output logic                     if_ack,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [WORD_BITWIDTH-1:0] d_addr,
    input  logic [WORD_BITWIDTH-1:0] d_wdata,
    input  logic [3:0]               d_be,
    output logic                     d_ack,
    output logic [WORD_BITWIDTH-1:0] rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WORD_BITWIDTH-1:0] mem_addr,
    output logic [WORD_BITWIDTH-1:0] mem_wdata,
    output logic [3:0]               mem_be,
    input  logic [WORD_BITWIDTH-1:0] mem_rdata,
    input  logic                     mem_ready
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    arb_state_e       state;
    grant_e           grant;
    logic             arb_en;
    logic             if_pend;
    logic             d_pend;
    logic             starve_inc;
    logic             starve_clr;
    logic             starve_sat;
    logic [CNT_W-1:0] starve_cnt;

    // Completion handshake is combinational so the requester sees it in the ready cycle.
    assign mem_req = (state != IDLE);
    assign if_ack  = (state == BUSY_I) && mem_ready;
    assign d_ack   = (state == BUSY_D) && mem_ready;
    assign rdata   = mem_rdata;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant   = GNT_NONE;
        arb_en  = (state == IDLE) || mem_ready;
        // The requester completing this cycle is still holding req; it is not a new request.
        if_pend = if_req && (state != BUSY_I);
        d_pend  = d_req  && (state != BUSY_D);
        if (arb_en) begin
            if (d_pend && !(if_pend && starve_sat)) begin
                grant = GNT_DATA;
            end else if (if_pend) begin
                grant = GNT_FETCH;
            end
        end
    end

    assign starve_inc = (grant == GNT_DATA) && if_req;
    assign starve_clr = (grant == GNT_FETCH) || !if_req;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat),
        .cnt   (starve_cnt)
    );

    // NOTE: the command registers are reset as well as the FSM, so the memory
    // never sees stale address or data from an abandoned transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= RESET_BE;
        end else begin
            unique case (grant)
                GNT_DATA: begin
                    state     <= BUSY_D;
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_be    <= d_be;
                end
                GNT_FETCH: begin
                    state    <= BUSY_I;
                    mem_we   <= 1'b0;
                    mem_addr <= if_addr;
                    mem_be   <= FETCH_BE;
                end
                default: begin
                    // Outside an arbitration cycle the command holds until mem_ready.
                    if (arb_en) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
